// File: rtl/y_signature_misr.sv
// y_signature_misr: compacts a wide observed bus into a Galois MISR signature.
// A run absorbs a programmed number of valid samples, then freezes the
// signature and compares it against a live expected value.
module y_signature_misr #(
    parameter int          WIDTH = 242,
    parameter int          SIG_W = 32,
    parameter logic [SIG_W-1:0] POLY  = 32'h04C11DB7,
    parameter logic [SIG_W-1:0] SEED  = 32'h00000000,
    parameter int          CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_vectors,
    input  logic [WIDTH-1:0] y,
    input  logic             y_valid,
    input  logic [SIG_W-1:0] exp_sig,
    output logic [SIG_W-1:0] sig,
    output logic [CNT_W-1:0] vec_count,
    output logic             busy,
    output logic             done,
    output logic             pass
);

    // Number of SIG_W-wide chunks after zero-padding the observed bus.
    localparam int NCH  = (WIDTH + SIG_W - 1) / SIG_W;
    localparam int PADW = NCH * SIG_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [SIG_W-1:0] sig_reg, sig_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] target_reg, target_next;

    logic [PADW-1:0]  y_pad;
    logic [SIG_W-1:0] fold_chain [0:NCH];
    logic [SIG_W-1:0] fold_val;
    logic [SIG_W-1:0] step_val;
    logic [CNT_W-1:0] cnt_plus;

    // Zero-pad the bus so it divides evenly into signature-wide chunks.
    always_comb begin
        y_pad             = '0;
        y_pad[WIDTH-1:0]  = y;
    end

    // XOR-reduce the chunks: bit k of y lands at fold bit k mod SIG_W.
    assign fold_chain[0] = '0;
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_fold
            assign fold_chain[gi+1] = fold_chain[gi] ^ y_pad[gi*SIG_W +: SIG_W];
        end
    endgenerate
    assign fold_val = fold_chain[NCH];

    // Galois shift: taps are applied when the MSB shifts out.
    assign step_val = {sig_reg[SIG_W-2:0], 1'b0} ^ (sig_reg[SIG_W-1] ? POLY : '0);
    assign cnt_plus = cnt_reg + CNT_W'(1);

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            sig_reg    <= SEED;
            cnt_reg    <= '0;
            target_reg <= '0;
        end else begin
            state_reg  <= state_next;
            sig_reg    <= sig_next;
            cnt_reg    <= cnt_next;
            target_reg <= target_next;
        end
    end

    // Next-state logic: start (re)loads a run, RUN absorbs valid samples.
    always_comb begin
        state_next  = state_reg;
        sig_next    = sig_reg;
        cnt_next    = cnt_reg;
        target_next = target_reg;
        case (state_reg)
            IDLE, DONE: begin
                // start takes priority; a coincident y is not absorbed.
                if (start) begin
                    sig_next    = SEED;
                    cnt_next    = '0;
                    target_next = num_vectors;
                    state_next  = (num_vectors == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (y_valid) begin
                    sig_next = step_val ^ fold_val;
                    cnt_next = cnt_plus;
                    if (cnt_plus == target_reg) begin
                        state_next = DONE;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign sig       = sig_reg;
    assign vec_count = cnt_reg;
    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    // pass follows exp_sig live while the signature is frozen in DONE.
    assign pass      = done && (sig_reg == exp_sig);

endmodule

// File: tb/tb_y_signature_misr.sv
// Self-checking bench for y_signature_misr using a scoreboard of expected
// end-of-run results pushed when a run is launched.
module tb_y_signature_misr;

    localparam int          WIDTH = 242;
    localparam int          SIG_W = 32;
    localparam int          CNT_W = 16;
    localparam logic [31:0] POLY  = 32'h04C11DB7;
    localparam logic [31:0] SEED  = 32'h00000000;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_vectors;
    logic [WIDTH-1:0] y;
    logic             y_valid;
    logic [SIG_W-1:0] exp_sig;
    logic [SIG_W-1:0] sig;
    logic [CNT_W-1:0] vec_count;
    logic             busy;
    logic             done;
    logic             pass;

    y_signature_misr #(
        .WIDTH(WIDTH), .SIG_W(SIG_W), .POLY(POLY), .SEED(SEED), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .y(y), .y_valid(y_valid), .exp_sig(exp_sig), .sig(sig),
        .vec_count(vec_count), .busy(busy), .done(done), .pass(pass)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] sig;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference signature update, straight from the bit-position definition.
    function automatic logic [31:0] model_absorb(input logic [31:0] s, input logic [WIDTH-1:0] yv);
        logic [31:0] f;
        f = '0;
        for (int k = 0; k < WIDTH; k++) f[k % 32] = f[k % 32] ^ yv[k];
        return ({s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0)) ^ f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [15:0] n);
        start       = 1'b1;
        num_vectors = n;
        tick();
        start       = 1'b0;
        num_vectors = 16'hFFFF;
    endtask

    task automatic feed(input logic [WIDTH-1:0] yv);
        y       = yv;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        y       = {WIDTH{1'b1}};
    endtask

    // Pop the scoreboard entry for the run that just finished and compare.
    task automatic finish_run();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
            return;
        end
        e = sb_q.pop_front();
        check({e.tag, "_done"}, done, 1);
        check({e.tag, "_busy"}, busy, 0);
        check({e.tag, "_sig"}, sig, e.sig);
        check({e.tag, "_cnt"}, vec_count, e.cnt);
        exp_sig = e.sig;
        #1;
        check({e.tag, "_pass"}, pass, 1);
        exp_sig = e.sig ^ 32'h1;
        #1;
        check({e.tag, "_nopass"}, pass, 0);
        $display("run %s: sig=0x%08h count=%0d", e.tag, sig, vec_count);
    endtask

    // Launch a run of back-to-back valid samples and check the result.
    task automatic run_seq(input string tag, input logic [WIDTH-1:0] ys[$], input logic [31:0] spec_sig);
        exp_t        e;
        logic [31:0] m;
        m = SEED;
        foreach (ys[i]) m = model_absorb(m, ys[i]);
        check({tag, "_model"}, m, spec_sig);
        e.tag = tag; e.sig = m; e.cnt = 16'(ys.size());
        sb_q.push_back(e);
        launch(16'(ys.size()));
        foreach (ys[i]) begin
            check({tag, "_busy_before"}, {busy, done}, 2'b10);
            feed(ys[i]);
        end
        finish_run();
    endtask

    logic [WIDTH-1:0] ys[$];
    logic [WIDTH-1:0] one;
    logic [31:0]      m;
    exp_t             e;
    int               waited;

    initial begin
        rst = 1'b1; start = 1'b0; num_vectors = '0; y = '0; y_valid = 1'b0; exp_sig = '0;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("reset_state", {sig, vec_count, busy, done, pass}, {SEED, 16'd0, 3'b000});

        ys = '{one};
        run_seq("single", ys, 32'h00000001);

        ys = '{one << 32};
        run_seq("bit32", ys, 32'h00000001);

        ys = '{one << 241};
        run_seq("bit241", ys, 32'h00020000);

        ys = '{{210'd0, 32'h80000000}, {WIDTH{1'b0}}};
        run_seq("poly", ys, 32'h04C11DB7);

        // Random payloads; expected values come from the reference model.
        ys = {};
        m  = SEED;
        for (int i = 0; i < 6; i++) begin
            logic [WIDTH-1:0] r;
            for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
            ys.push_back(r);
            m = model_absorb(m, r);
        end
        run_seq("random", ys, m);

        // Gaps: invalid cycles hold state, DONE only after second valid.
        e.tag = "gaps"; e.sig = 32'h00000002; e.cnt = 16'd2;
        sb_q.push_back(e);
        launch(16'd2);
        feed(one);
        for (int i = 0; i < 3; i++) begin
            y = {WIDTH{1'b1}};
            tick();
            check("gaps_hold", {busy, done, vec_count, sig}, {2'b10, 16'd1, 32'h1});
        end
        feed({WIDTH{1'b0}});
        finish_run();

        // Zero count goes straight to DONE with the seed.
        e.tag = "zero"; e.sig = SEED; e.cnt = 16'd0;
        sb_q.push_back(e);
        launch(16'd0);
        finish_run();

        // start inside RUN is ignored; coincident sample is still absorbed.
        ys = {};
        for (int i = 0; i < 3; i++) ys.push_back(WIDTH'($urandom) << (i * 64));
        m = SEED;
        foreach (ys[i]) m = model_absorb(m, ys[i]);
        e.tag = "start_in_run"; e.sig = m; e.cnt = 16'd3;
        sb_q.push_back(e);
        launch(16'd3);
        feed(ys[0]);
        start = 1'b1;
        num_vectors = 16'd0;
        feed(ys[1]);
        start = 1'b0;
        check("start_in_run_cnt", {busy, vec_count}, {1'b1, 16'd2});
        waited = 0;
        y = ys[2];
        y_valid = 1'b1;
        while (!done && waited < 20) begin
            tick();
            y_valid = 1'b0;
            waited++;
        end
        check("start_in_run_timeout", (waited < 20), 1);
        finish_run();

        // start with y_valid in DONE restarts and ignores the sample.
        start = 1'b1; num_vectors = 16'd4; y = one; y_valid = 1'b1;
        tick();
        start = 1'b0; y_valid = 1'b0;
        check("restart_in_done", {sig, vec_count, busy, done}, {SEED, 16'd0, 2'b10});
        $display("restart: sig=0x%08h count=%0d busy=%0b", sig, vec_count, busy);

        // Async reset mid-run, asserted away from any clock edge.
        feed(one);
        feed(one << 7);
        check("pre_reset_busy", {busy, vec_count}, {1'b1, 16'd2});
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", {sig, vec_count, busy, done, pass}, {SEED, 16'd0, 3'b000});
        $display("async reset: sig=0x%08h busy=%0b done=%0b", sig, busy, done);
        #1;
        rst = 1'b0;
        tick();
        check("post_reset_idle", {busy, done, vec_count}, {2'b00, 16'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/y_signature_misr.md
Name: y_signature_misr

Overview:
- Downstream consumer of the fuzzed design's `y` bus; sits in the simulation harness after the synthesized top.
- Compacts the 242-bit `y` sampled on each valid clock edge into a 32-bit multiple-input signature register (MISR).
- After a programmed vector count, compares the signature against an expected value.
- Replaces per-cycle `$strobe` text dumps: one signature per run for cross-simulator/cross-synthesizer equivalence checks.

Parameters:
- WIDTH, 242, width of observed `y` bus
- SIG_W, 32, signature width
- POLY, 32'h04C11DB7, feedback polynomial (Galois, taps XORed when MSB shifts out)
- SEED, 32'h00000000, signature value loaded on start
- CNT_W, 16, vector counter width

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  pulse: begin a capture run (honoured only in IDLE or DONE)
- num_vectors  input  CNT_W  number of valid samples to absorb; sampled on start
- y  input  WIDTH  observed bus from design under test
- y_valid  input  1  `y` is to be absorbed this cycle
- exp_sig  input  SIG_W  expected signature; compared combinationally in DONE
- sig  output  SIG_W  current signature
- vec_count  output  CNT_W  samples absorbed in current run
- busy  output  1  high in RUN
- done  output  1  high in DONE
- pass  output  1  done && (sig == exp_sig); 0 outside DONE

Behaviour:
- Reset (async assert, sync deassert at clk):
  - state=IDLE
  - sig=SEED, vec_count=0, stored target=0
  - busy=done=pass=0
- Fold: zero-pad `y` to ceil(WIDTH/SIG_W)*SIG_W bits (256 for defaults).
  - Split into SIG_W chunks, chunk0 = y[SIG_W-1:0].
  - fold(y) = XOR of all chunks. Bit k of `y` lands at fold bit k mod SIG_W.
- Step: step(s) = {s[SIG_W-2:0],1'b0} ^ (s[SIG_W-1] ? POLY : 0).
- Update per absorbed sample: sig <= step(sig) ^ fold(y).
- FSM states IDLE, RUN, DONE (registered outputs busy/done, 1-cycle visibility after edge):
  - IDLE:
    - start=1 → sig<=SEED, vec_count<=0, target<=num_vectors.
    - Go to RUN, or directly to DONE if num_vectors==0 (sig stays SEED).
    - y_valid ignored.
  - RUN: each cycle with y_valid=1 → update sig, vec_count+1.
    - If vec_count+1 == target, go to DONE on the same edge.
    - y_valid=0 → hold everything.
    - start ignored.
  - DONE: sig and vec_count frozen; y_valid ignored.
    - start=1 → same action as from IDLE (restart, reloads SEED).
- Simultaneous start and y_valid in IDLE/DONE: start wins; that `y` is not absorbed.
- vec_count never wraps within a run, since target ≤ 2^CNT_W−1.
- num_vectors changes after start have no effect.
- Reset mid-RUN: immediate return to reset values; no partial done/pass.
- pass is combinational from frozen sig and live exp_sig; recomputes if exp_sig changes while in DONE.
- Latency: the sample absorbed at edge N is reflected in sig after edge N. Final sig, done and pass are valid after the edge absorbing the last sample.

Test Plan:
- Reset: rst pulsed mid-simulation with no clk edge → sig=0, busy=done=pass=0 immediately.
- Single sample: start, num_vectors=1, y=1 valid one cycle → DONE, sig=32'h00000001, vec_count=1; exp_sig=1 → pass=1, exp_sig=2 → pass=0.
- Fold position:
  - y with only bit 32 set → sig=32'h00000001.
  - y with only bit 241 set → sig=32'h00020000.
- Polynomial feedback: num_vectors=2, y=32'h80000000 then y=0 → sig=32'h04C11DB7, vec_count=2.
- Gaps and zero count:
  - num_vectors=2, sequence valid(y=1), invalid ×3, valid(y=0) → DONE only after 2nd valid, sig=32'h00000002.
  - num_vectors=0 → DONE one edge after start, sig=SEED.
- Control corners:
  - start asserted in RUN after 1 of 3 samples → ignored; run completes with count 3.
  - start with y_valid=1 in DONE → restart, sig=SEED, vec_count=0.
  - rst mid-RUN → IDLE with reset values.
